phys_regfile: RTL and testbench

- Parametrised multi-port physical register file for the out-of-order core; successor to the single-write, two-read architectural register file.
- Holds 2**PREG_W physical registers plus a per-register ready bit, i.e. a scoreboard.
- Rename/dispatch allocates destination registers, which clears their ready bits. Writeback ports write data and set the ready bits.
- Read ports return data with same-cycle write bypass.
- A post-reset sweep FSM zeroes the whole array before the core is released.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/phys_regfile_if.sv | 32 +++
 rtl/rf_bypass_mux.sv | 35 +++
 rtl/phys_regfile.sv | 110 +++++++++++
 tb/tb_phys_regfile.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared sizing defaults and types for the physical register file slice.
package cpu_pkg;

    localparam int PREG_W    = 6;
    localparam int DATA_W    = 32;
    localparam int NUM_RD    = 4;
    localparam int NUM_WR    = 2;
    localparam int NUM_ALLOC = 2;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/phys_regfile_if.sv
// Core-side bundle of the physical register file: alloc, writeback, read and debug ports.
interface phys_regfile_if #(
    parameter int PREG_W    = cpu_pkg::PREG_W,
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int NUM_RD    = cpu_pkg::NUM_RD,
    parameter int NUM_WR    = cpu_pkg::NUM_WR,
    parameter int NUM_ALLOC = cpu_pkg::NUM_ALLOC
);

    logic [NUM_ALLOC-1:0]        alloc_valid;
    logic [NUM_ALLOC*PREG_W-1:0] alloc_preg;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR*PREG_W-1:0]    wr_addr;
    logic [NUM_WR*DATA_W-1:0]    wr_data;
    logic [NUM_RD*PREG_W-1:0]    rd_addr;
    logic [NUM_RD*DATA_W-1:0]    rd_data;
    logic [NUM_RD-1:0]           rd_ready;
    logic [PREG_W-1:0]           dbg_addr;
    logic [DATA_W-1:0]           dbg_data;
    logic                        init_done;

    modport master (
        output alloc_valid, alloc_preg, wr_en, wr_addr, wr_data, rd_addr, dbg_addr,
        input  rd_data, rd_ready, dbg_data, init_done
    );

    modport slave (
        input  alloc_valid, alloc_preg, wr_en, wr_addr, wr_data, rd_addr, dbg_addr,
        output rd_data, rd_ready, dbg_data, init_done
    );

endinterface

// File: rtl/rf_bypass_mux.sv
// One read port: highest-index matching writeback wins over the array, p0 and the
// init sweep force data 0 / ready 1.
module rf_bypass_mux #(
    parameter int PREG_W = cpu_pkg::PREG_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int NUM_WR = cpu_pkg::NUM_WR
) (
    input  logic                     run,
    input  logic [PREG_W-1:0]        rd_addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*PREG_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic                     rf_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_ready
);

    always_comb begin
        rd_data  = rf_data;
        rd_ready = rf_ready;
        // ascending scan so the highest matching port is the last to assign
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i*PREG_W +: PREG_W] == rd_addr)) begin
                rd_data  = wr_data[i*DATA_W +: DATA_W];
                rd_ready = 1'b1;
            end
        end
        if (!run || (rd_addr == '0)) begin
            rd_data  = '0;
            rd_ready = 1'b1;
        end
    end

endmodule

// File: rtl/phys_regfile.sv
// Multi-port physical register file with ready scoreboard and a post-reset zeroing sweep.
module phys_regfile #(
    parameter int PREG_W    = cpu_pkg::PREG_W,
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int NUM_RD    = cpu_pkg::NUM_RD,
    parameter int NUM_WR    = cpu_pkg::NUM_WR,
    parameter int NUM_ALLOC = cpu_pkg::NUM_ALLOC
) (
    input  logic          clock,
    input  logic          reset,
    phys_regfile_if.slave bus
);

    localparam int NUM_PREG = 1 << PREG_W;

    logic [DATA_W-1:0]             rf [NUM_PREG];
    logic [NUM_PREG-1:0]           ready;
    cpu_pkg::rf_state_e            state, state_nxt;
    logic [PREG_W-1:0]             sweep_cnt;
    logic                          run;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_a;
    logic [NUM_RD-1:0]             rd_ready_a;

    assign run = (state == cpu_pkg::RF_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= cpu_pkg::RF_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            cpu_pkg::RF_INIT: if (sweep_cnt == {PREG_W{1'b1}}) state_nxt = cpu_pkg::RF_RUN;
            cpu_pkg::RF_RUN:  state_nxt = cpu_pkg::RF_RUN;
            default:          state_nxt = cpu_pkg::RF_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sweep_cnt <= '0;
        end else if (!run) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    // array itself is not reset; the sweep provides the zeroing
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!run) begin
                rf[sweep_cnt] <= '0;
            end else begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (bus.wr_en[i] && (bus.wr_addr[i*PREG_W +: PREG_W] != '0)) begin
                        rf[bus.wr_addr[i*PREG_W +: PREG_W]] <= bus.wr_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // allocs are applied after writes so a same-cycle alloc leaves the register not ready
    always_ff @(posedge clock) begin
        if (reset) begin
            ready <= '1;
        end else if (run) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (bus.wr_en[i] && (bus.wr_addr[i*PREG_W +: PREG_W] != '0)) begin
                    ready[bus.wr_addr[i*PREG_W +: PREG_W]] <= 1'b1;
                end
            end
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (bus.alloc_valid[j] && (bus.alloc_preg[j*PREG_W +: PREG_W] != '0)) begin
                    ready[bus.alloc_preg[j*PREG_W +: PREG_W]] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [PREG_W-1:0] addr;
        assign addr = bus.rd_addr[k*PREG_W +: PREG_W];

        rf_bypass_mux #(
            .PREG_W (PREG_W),
            .DATA_W (DATA_W),
            .NUM_WR (NUM_WR)
        ) u_mux (
            .run      (run),
            .rd_addr  (addr),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .rf_data  (rf[addr]),
            .rf_ready (ready[addr]),
            .rd_data  (rd_data_a[k]),
            .rd_ready (rd_ready_a[k])
        );
    end

    assign bus.rd_data   = rd_data_a;
    assign bus.rd_ready  = rd_ready_a;
    assign bus.dbg_data  = rf[bus.dbg_addr];
    assign bus.init_done = run;

endmodule

// File: tb/tb_phys_regfile.sv
// Bench for phys_regfile: per-cycle scoreboard compare plus directed literal checks.
module tb_phys_regfile;

    localparam int PW = 6;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int NA = 2;
    localparam int NP = 64;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    phys_regfile_if #(.PREG_W(PW), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW), .NUM_ALLOC(NA)) bus ();

    phys_regfile #(.PREG_W(PW), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW), .NUM_ALLOC(NA)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // reference state: register contents, which ones are defined, readiness, sweep progress
    logic [DW-1:0] m_rf [NP];
    bit            m_valid [NP];
    bit            m_rdy [NP];
    int            m_cnt = 0;
    bit            m_done = 1'b0;
    bit            m_started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_cnt     = 0;
            m_done    = 1'b0;
            m_started = 1'b1;
            for (int p = 0; p < NP; p++) m_rdy[p] = 1'b1;
        end else if (m_started) begin
            if (!m_done) begin
                m_rf[m_cnt]    = '0;
                m_valid[m_cnt] = 1'b1;
                m_cnt++;
                if (m_cnt == NP) m_done = 1'b1;
            end else begin
                for (int i = 0; i < NW; i++) begin
                    int a;
                    a = int'(bus.wr_addr[i*PW +: PW]);
                    if (bus.wr_en[i] && a != 0) begin
                        m_rf[a]    = bus.wr_data[i*DW +: DW];
                        m_valid[a] = 1'b1;
                        m_rdy[a]   = 1'b1;
                    end
                end
                for (int j = 0; j < NA; j++) begin
                    int a;
                    a = int'(bus.alloc_preg[j*PW +: PW]);
                    if (bus.alloc_valid[j] && a != 0) m_rdy[a] = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_started) begin
            chk("init_done", {63'd0, bus.init_done}, {63'd0, m_done});
            for (int k = 0; k < NR; k++) begin
                int            a;
                logic [DW-1:0] ed;
                logic          er;
                a  = int'(bus.rd_addr[k*PW +: PW]);
                ed = '0;
                er = 1'b1;
                if (m_done && a != 0) begin
                    ed = m_rf[a];
                    er = m_rdy[a];
                    for (int i = 0; i < NW; i++) begin
                        if (bus.wr_en[i] && int'(bus.wr_addr[i*PW +: PW]) == a) begin
                            ed = bus.wr_data[i*DW +: DW];
                            er = 1'b1;
                        end
                    end
                end
                chk($sformatf("rd_data[%0d]", k), {32'd0, bus.rd_data[k*DW +: DW]}, {32'd0, ed});
                chk($sformatf("rd_ready[%0d]", k), {63'd0, bus.rd_ready[k]}, {63'd0, er});
            end
            if (m_valid[bus.dbg_addr]) begin
                chk("dbg_data", {32'd0, bus.dbg_data}, {32'd0, m_rf[bus.dbg_addr]});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_valid = '0;
        bus.alloc_preg  = '0;
        bus.wr_en       = '0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (!bus.init_done && n < 200) begin
            tick();
            n++;
        end
        chk(name, 64'(n), 64'd64);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            m_valid[p] = 1'b0;
            m_rdy[p]   = 1'b1;
            m_rf[p]    = '0;
        end
        idle_inputs();
        bus.rd_addr  = '0;
        bus.dbg_addr = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_init_done", {63'd0, bus.init_done}, 64'd0);
        bus.rd_addr = {6'd63, 6'd3, 6'd2, 6'd1};
        #1;
        chk("init_rdy_all", {60'd0, bus.rd_ready}, 64'hF);
        chk("init_rd_zero", {bus.rd_data[DW +: DW], bus.rd_data[0 +: DW]}, 64'd0);
        count_init("init_len");

        for (int p = 0; p < NP; p++) begin
            bus.dbg_addr = PW'(p);
            #1;
            chk("sweep_zero", {32'd0, bus.dbg_data}, 64'd0);
        end
        #1;
        chk("run_rdy_all", {60'd0, bus.rd_ready}, 64'hF);

        // alloc p5, then writeback with same-cycle bypass
        bus.alloc_valid = 2'b01;
        bus.alloc_preg[0 +: PW] = 6'd5;
        tick();
        idle_inputs();
        bus.rd_addr[0 +: PW] = 6'd5;
        #1;
        chk("alloc_p5_rdy", {63'd0, bus.rd_ready[0]}, 64'd0);
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: PW] = 6'd5;
        bus.wr_data[0 +: DW] = 32'hDEADBEEF;
        #1;
        chk("byp_p5_data", {32'd0, bus.rd_data[0 +: DW]}, 64'hDEADBEEF);
        chk("byp_p5_rdy", {63'd0, bus.rd_ready[0]}, 64'd1);
        tick();
        idle_inputs();
        bus.dbg_addr = 6'd5;
        #1;
        chk("dbg_p5", {32'd0, bus.dbg_data}, 64'hDEADBEEF);

        // both ports to p9, port 1 wins
        bus.wr_en   = 2'b11;
        bus.wr_addr = {6'd9, 6'd9};
        bus.wr_data = {32'h22, 32'h11};
        bus.rd_addr[PW +: PW] = 6'd9;
        #1;
        chk("byp_p9", {32'd0, bus.rd_data[DW +: DW]}, 64'h22);
        tick();
        idle_inputs();
        bus.dbg_addr = 6'd9;
        #1;
        chk("dbg_p9", {32'd0, bus.dbg_data}, 64'h22);
        chk("rd_p9", {32'd0, bus.rd_data[DW +: DW]}, 64'h22);

        // alloc and write p12 together: data lands, ready ends cleared
        bus.alloc_valid = 2'b10;
        bus.alloc_preg[PW +: PW] = 6'd12;
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: PW] = 6'd12;
        bus.wr_data[0 +: DW] = 32'h33;
        tick();
        idle_inputs();
        bus.rd_addr[2*PW +: PW] = 6'd12;
        #1;
        chk("p12_data", {32'd0, bus.rd_data[2*DW +: DW]}, 64'h33);
        chk("p12_rdy", {63'd0, bus.rd_ready[2]}, 64'd0);

        // p0 stays zero and ready
        bus.wr_en = 2'b10;
        bus.wr_addr[PW +: PW] = 6'd0;
        bus.wr_data[DW +: DW] = 32'hFFFFFFFF;
        bus.alloc_valid = 2'b10;
        bus.alloc_preg[PW +: PW] = 6'd0;
        bus.rd_addr[3*PW +: PW] = 6'd0;
        #1;
        chk("p0_data_now", {32'd0, bus.rd_data[3*DW +: DW]}, 64'd0);
        chk("p0_rdy_now", {63'd0, bus.rd_ready[3]}, 64'd1);
        tick();
        idle_inputs();
        bus.dbg_addr = 6'd0;
        #1;
        chk("p0_data_after", {32'd0, bus.rd_data[3*DW +: DW]}, 64'd0);
        chk("p0_rdy_after", {63'd0, bus.rd_ready[3]}, 64'd1);
        chk("p0_dbg", {32'd0, bus.dbg_data}, 64'd0);

        // p7 survives a reset until the sweep reaches it; INIT writes are ignored
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: PW] = 6'd7;
        bus.wr_data[0 +: DW] = 32'hA5;
        tick();
        idle_inputs();
        bus.dbg_addr = 6'd7;
        bus.rd_addr[0 +: PW] = 6'd7;
        #1;
        chk("p7_written", {32'd0, bus.dbg_data}, 64'hA5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.wr_en = 2'b01;
        bus.wr_addr[0 +: PW] = 6'd7;
        bus.wr_data[0 +: DW] = 32'h77;
        bus.alloc_valid = 2'b01;
        bus.alloc_preg[0 +: PW] = 6'd7;
        tick();
        tick();
        tick();
        chk("midsweep_done", {63'd0, bus.init_done}, 64'd0);
        chk("init_wr_ignored", {32'd0, bus.dbg_data}, 64'hA5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_init("reinit_len");
        idle_inputs();
        #1;
        chk("p7_cleared", {32'd0, bus.dbg_data}, 64'd0);
        chk("p7_rd_data", {32'd0, bus.rd_data[0 +: DW]}, 64'd0);
        chk("p7_rd_rdy", {63'd0, bus.rd_ready[0]}, 64'd1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
